// File: rtl/ds1302_pkg.sv
// ============================================================================
// Module   : ds1302_pkg
// Purpose  : Shared types, DS1302 command bytes and the burst step table.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ds1302_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_NEXT   = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    localparam logic [7:0] SEC_RD = 8'h81;
    localparam logic [7:0] MIN_RD = 8'h83;
    localparam logic [7:0] HR_RD  = 8'h85;
    localparam logic [7:0] SEC_WR = 8'h80;
    localparam logic [7:0] MIN_WR = 8'h82;
    localparam logic [7:0] HR_WR  = 8'h84;
    localparam logic [7:0] WP_WR  = 8'h8E;

    localparam logic [7:0] WP_SET = 8'h80;
    localparam logic [7:0] WP_CLR = 8'h00;

    localparam logic [2:0] RD_LEN = 3'd3;
    localparam logic [2:0] WR_LEN = 3'd5;

    // Returns {cmd, data} for one step of a burst.
    function automatic logic [15:0] step_entry(
        input logic       is_wr,
        input logic [2:0] step,
        input logic [7:0] s,
        input logic [7:0] m,
        input logic [7:0] h
    );
        logic [15:0] e;
        e = 16'h0000;
        if (is_wr) begin
            case (step)
                3'd0:    e = {WP_WR,  WP_CLR};
                3'd1:    e = {SEC_WR, s};
                3'd2:    e = {MIN_WR, m};
                3'd3:    e = {HR_WR,  h};
                default: e = {WP_WR,  WP_SET};
            endcase
        end else begin
            case (step)
                3'd0:    e = {SEC_RD, 8'h00};
                3'd1:    e = {MIN_RD, 8'h00};
                default: e = {HR_RD,  8'h00};
            endcase
        end
        return e;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ds1302_watchdog.sv
// ============================================================================
// Module   : ds1302_watchdog
// Purpose  : Per-transaction timeout counter; o_expire flags the last cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ds1302_watchdog #(
    parameter int TIMEOUT_CYC = 10000,
    parameter int TO_W        = 14
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [TO_W-1:0] c_last = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] r_cnt;

    // Saturates at the terminal count so a stalled FSM cannot wrap it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != c_last)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/ds1302_txn_sched.sv
// ============================================================================
// Module   : ds1302_txn_sched
// Purpose  : Arbitrates read/write requests and sequences DS1302 bursts.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ds1302_txn_sched
    import ds1302_pkg::*;
#(
    parameter int TIMEOUT_CYC = 10000,
    parameter int TO_W        = 14
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       setReq,
    input  logic [7:0] setSec,
    input  logic [7:0] setMin,
    input  logic [7:0] setHour,
    output logic       txStart,
    output logic [7:0] txCmd,
    output logic [7:0] txWrData,
    input  logic       txDone,
    input  logic [7:0] txRdData,
    output logic [7:0] sec,
    output logic [7:0] min,
    output logic [7:0] hour,
    output logic       chHalt,
    output logic       timeValid,
    output logic       setAck,
    output logic       errPulse,
    output logic       busy
);

    state_t      r_state;
    state_t      w_next;
    logic        r_rd_pend, r_wr_pend;
    logic [7:0]  r_sh_sec, r_sh_min, r_sh_hour;
    logic        r_is_wr;
    logic [2:0]  r_step;
    logic [7:0]  r_cmd, r_wdata;
    logic [7:0]  r_stg_sec, r_stg_min, r_stg_hour;
    logic [7:0]  r_sec, r_min, r_hour;
    logic        r_ch, r_tv, r_ack;
    logic        w_take_wr, w_take_rd, w_err, w_last, w_expire;

    assign w_last = (r_step == (r_is_wr ? (WR_LEN - 3'd1) : (RD_LEN - 3'd1)));

    ds1302_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_W        (TO_W)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (r_state == ST_ISSUE),
        .i_en     ((r_state == ST_WAIT) && !txDone),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_take_wr = 1'b0;
        w_take_rd = 1'b0;
        w_err     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_wr_pend) begin
                    w_take_wr = 1'b1;
                    w_next    = ST_ISSUE;
                end else if (r_rd_pend) begin
                    w_take_rd = 1'b1;
                    w_next    = ST_ISSUE;
                end
            end
            ST_ISSUE: w_next = ST_WAIT;
            ST_WAIT: begin
                if (txDone) begin
                    w_next = ST_NEXT;
                end else if (w_expire) begin
                    w_err  = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            ST_NEXT:   w_next = w_last ? ST_FINISH : ST_ISSUE;
            ST_FINISH: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // A new request in the cycle its flag is consumed must survive, so set wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_pend <= 1'b0;
            r_wr_pend <= 1'b0;
            r_sh_sec  <= 8'h00;
            r_sh_min  <= 8'h00;
            r_sh_hour <= 8'h00;
        end else begin
            if (tick)           r_rd_pend <= 1'b1;
            else if (w_take_rd) r_rd_pend <= 1'b0;
            if (setReq) begin
                r_wr_pend <= 1'b1;
                r_sh_sec  <= setSec & 8'h7F;
                r_sh_min  <= setMin;
                r_sh_hour <= setHour & 8'h3F;
            end else if (w_take_wr) begin
                r_wr_pend <= 1'b0;
            end
        end
    end

    // Command/data are registered at step launch so they hold through WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_is_wr <= 1'b0;
            r_step  <= 3'd0;
            r_cmd   <= 8'h00;
            r_wdata <= 8'h00;
        end else if (w_take_wr || w_take_rd) begin
            r_is_wr          <= w_take_wr;
            r_step           <= 3'd0;
            {r_cmd, r_wdata} <= step_entry(w_take_wr, 3'd0, r_sh_sec, r_sh_min, r_sh_hour);
        end else if ((r_state == ST_NEXT) && !w_last) begin
            r_step           <= r_step + 3'd1;
            {r_cmd, r_wdata} <= step_entry(r_is_wr, r_step + 3'd1, r_sh_sec, r_sh_min, r_sh_hour);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stg_sec  <= 8'h00;
            r_stg_min  <= 8'h00;
            r_stg_hour <= 8'h00;
        end else if ((r_state == ST_WAIT) && txDone && !r_is_wr) begin
            case (r_step)
                3'd0:    r_stg_sec  <= txRdData;
                3'd1:    r_stg_min  <= txRdData;
                default: r_stg_hour <= txRdData;
            endcase
        end
    end

    // Time outputs and their strobe update together so consumers see one set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sec  <= 8'h00;
            r_min  <= 8'h00;
            r_hour <= 8'h00;
            r_ch   <= 1'b0;
            r_tv   <= 1'b0;
            r_ack  <= 1'b0;
        end else begin
            r_tv  <= (r_state == ST_FINISH) && !r_is_wr;
            r_ack <= (r_state == ST_FINISH) && r_is_wr;
            if ((r_state == ST_FINISH) && !r_is_wr) begin
                r_sec  <= r_stg_sec & 8'h7F;
                r_ch   <= r_stg_sec[7];
                r_min  <= r_stg_min;
                r_hour <= r_stg_hour & 8'h3F;
            end
        end
    end

    assign txStart   = (r_state == ST_ISSUE);
    assign txCmd     = r_cmd;
    assign txWrData  = r_wdata;
    assign sec       = r_sec;
    assign min       = r_min;
    assign hour      = r_hour;
    assign chHalt    = r_ch;
    assign timeValid = r_tv;
    assign setAck    = r_ack;
    assign errPulse  = w_err;
    assign busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: doc/ds1302_txn_sched.md
Name: ds1302_txn_sched

Overview:
- Transaction scheduler that sits above the byte-level DS1302 serial engine and sequences multi-register accesses through it.
- Shares the single engine between two requesters: the periodic 1 s time-read trigger and the user set-time write request.
- Read bursts return an atomically committed BCD seconds, minutes and hours set to the FND path.
- Write bursts perform the full sequence: write-protect clear, time write, write-protect restore.

Parameters:
- TIMEOUT_CYC, 10000: clk cycles allowed between txStart and txDone before a transaction is aborted.
- TO_W, 14: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle read trigger (1 s tick).
- setReq  in  1  one-cycle write request; setSec, setMin and setHour are sampled in the same cycle.
- setSec  in  8  BCD seconds to write.
- setMin  in  8  BCD minutes to write.
- setHour  in  8  BCD hours to write (24 h).
- txStart  out  1  one-cycle pulse that launches one engine transaction.
- txCmd  out  8  DS1302 command byte.
- txWrData  out  8  write data byte; don't-care for reads.
- txDone  in  1  one-cycle pulse from the engine when the transaction completes.
- txRdData  in  8  read byte; valid while txDone is high.
- sec  out  8  BCD seconds with the CH bit masked.
- min  out  8  BCD minutes.
- hour  out  8  BCD hours, masked with 0x3F.
- chHalt  out  1  CH bit of the last committed seconds read.
- timeValid  out  1  one-cycle pulse when sec, min and hour update.
- setAck  out  1  one-cycle pulse when a write burst completes.
- errPulse  out  1  one-cycle pulse when a transaction times out.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs are 0.
  - Pending flags, step index and timeout counter are cleared.
  - FSM goes to IDLE.
  - A reset mid-burst abandons the burst with no commit; txStart is 0 immediately.
- Request capture (every cycle, independent of state):
  - tick sets readPend.
  - setReq sets writePend and loads the shadow registers with {setSec & 0x7F, setMin, setHour & 0x3F}.
  - Extra ticks while readPend is set coalesce into one pending read.
  - A newer setReq overwrites the shadow data.
- Arbitration in IDLE: writePend has priority over readPend. When tick and setReq arrive in the same cycle, the write burst runs first and the read follows immediately after.
- Read burst steps (cmd): 0x81, 0x83, 0x85.
- Write burst steps (cmd/data):
  - 0x8E / 0x00 (clear write protect)
  - 0x80 / sec
  - 0x82 / min
  - 0x84 / hour
  - 0x8E / 0x80 (restore write protect)
- FSM states: IDLE, ISSUE, WAIT, NEXT, FINISH.
- IDLE:
  - If a request is pending, clear that pending flag, select the burst, set step=0 and go to ISSUE.
  - The pending flag is cleared when it is consumed, so a request arriving during the burst re-sets it.
- ISSUE:
  - txStart=1 for one cycle.
  - txCmd and txWrData are driven from the step table.
  - Clear the timeout counter; go to WAIT.
- txCmd and txWrData are held stable from ISSUE until the txDone of that step.
- WAIT:
  - On txDone: for a read burst, capture txRdData into staging register[step]; then go to NEXT.
  - Otherwise increment the timeout counter.
  - When the counter reaches TIMEOUT_CYC-1 without txDone: errPulse=1, the burst is aborted with no commit and no setAck, and the FSM returns to IDLE.
  - An aborted write is dropped unless setReq re-arrives.
- NEXT: if step is the last step of the burst, go to FINISH; otherwise step++ and go to ISSUE.
- Inter-transaction gap: the next txStart is 2 cycles after the txDone of the previous step.
- FINISH:
  - For a read burst, all of the following take effect in the same cycle:
    - sec = staged sec & 0x7F
    - chHalt = staged sec bit 7
    - min = staged min
    - hour = staged hour & 0x3F
    - timeValid=1
  - For a write burst, setAck=1.
  - Then go to IDLE.
- Latency: from tick in IDLE to the first txStart is 2 cycles (IDLE→ISSUE, then the pulse).
- A txDone received outside WAIT is ignored.
- busy is high in ISSUE, WAIT, NEXT and FINISH.

Decomposition:
- Package ds1302_pkg holds:
  - the state enum;
  - command constants SEC_RD=0x81, MIN_RD=0x83, HR_RD=0x85, SEC_WR=0x80, MIN_WR=0x82, HR_WR=0x84, WP_WR=0x8E;
  - WP_SET=0x80, WP_CLR=0x00;
  - burst lengths RD_LEN=3 and WR_LEN=5.
- One sub-module, ds1302_watchdog: timeout counter with clear and enable inputs and an expire output, parameterised by TIMEOUT_CYC.

Test Plan:
- Read burst:
  - Stimulus: tick; engine model returns 0x45, 0x32, 0x12, each with txDone 20 cycles after txStart.
  - Expected: txCmd sequence 0x81, 0x83, 0x85; sec=0x45, min=0x32, hour=0x12; timeValid exactly once, coincident with the update; chHalt=0.
- Clock-halt masking:
  - Stimulus: read burst where the engine returns 0xD9 for seconds.
  - Expected: sec=0x59, chHalt=1.
- Write burst:
  - Stimulus: setReq with 0x30, 0x15, 0x23.
  - Expected: cmd/data pairs 8E/00, 80/30, 82/15, 84/23, 8E/80; setAck once; no timeValid.
- Simultaneous requests:
  - Stimulus: tick and setReq in the same cycle; three more ticks during the write.
  - Expected: write burst first, then exactly one read burst; busy stays high with no IDLE gap longer than one cycle.
- Timeout:
  - Stimulus: engine never asserts txDone on the minutes read.
  - Expected: errPulse at TIMEOUT_CYC cycles after that txStart; sec, min and hour keep their previous values; the next tick runs a normal burst.
- Reset mid-burst:
  - Stimulus: rst=0 during WAIT of write step 2.
  - Expected: all outputs 0 asynchronously; no setAck; after release, IDLE with no pending requests.
